multi_player_stats: RTL and testbench

MULTI_PLAYER_STATS -- requirements
Module: multi_player_stats

---
 rtl/multi_player_stats.sv | 185 ++++++++++++++++++
 tb/tb_multi_player_stats.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_player_stats.sv
// Score, lives and turn tracker for up to four players with BCD scores and bonus lives.
// Optional high-score register enabled by defining MULTI_PLAYER_STATS_HISCORE_EN.
module multi_player_stats #(
  parameter int                        NUM_PLAYERS  = 2,
  parameter int                        SCORE_DIGITS = 4,
  parameter int                        START_LIVES  = 3,
  parameter int                        MAX_LIVES    = 9,
  parameter logic [SCORE_DIGITS*4-1:0] BONUS_SCORE  = 'h1000,
  localparam int                       PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int                       SW = SCORE_DIGITS * 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     add_pts,
  input  logic [3:0]               add_val,
  input  logic [2:0]               add_pos,
  input  logic                     declives,
  output logic [NUM_PLAYERS*SW-1:0] scores,
  output logic [NUM_PLAYERS*4-1:0]  lives,
  output logic [PW-1:0]            cur_player,
  output logic                     playing,
  output logic                     game_over,
  output logic [SW-1:0]            hiscore,
  output logic                     new_hiscore
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

  state_t                 state_q, state_d;
  logic [SW-1:0]          score_q [NUM_PLAYERS];
  logic [SW-1:0]          score_d [NUM_PLAYERS];
  logic [3:0]             lives_q [NUM_PLAYERS];
  logic [3:0]             lives_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] bonus_q, bonus_d;
  logic [PW-1:0]          cur_q, cur_d;

  // Adds one digit at a chosen position with full ripple carry; overflow pins to all nines.
  function automatic logic [SW-1:0] bcd_add(input logic [SW-1:0] a,
                                            input logic [3:0]    val,
                                            input logic [2:0]    pos);
    logic [SW-1:0] r;
    logic [3:0]    v;
    logic [4:0]    s;
    logic          c;
    r = '0;
    c = 1'b0;
    v = (val > 4'd9) ? 4'd0 : val;
    for (int d = 0; d < SCORE_DIGITS; d++) begin
      s = {1'b0, a[d*4 +: 4]} + {4'b0, c} + ((int'(pos) == d) ? {1'b0, v} : 5'd0);
      if (s > 5'd9) begin
        r[d*4 +: 4] = 4'(s - 5'd10);
        c           = 1'b1;
      end else begin
        r[d*4 +: 4] = s[3:0];
        c           = 1'b0;
      end
    end
    if (c) r = {SCORE_DIGITS{4'h9}};
    return r;
  endfunction

  always_comb begin
    logic grant;
    logic dec;
    logic found;
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    bonus_d = bonus_q;
    cur_d   = cur_q;
    grant   = 1'b0;
    dec     = 1'b0;
    found   = 1'b0;

    if (start) begin
      state_d = S_PLAY;
      cur_d   = '0;
      bonus_d = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        score_d[p] = '0;
        lives_d[p] = 4'(START_LIVES);
      end
    end else if (state_q == S_PLAY) begin
      if (add_pts) score_d[cur_q] = bcd_add(score_q[cur_q], add_val, add_pos);

      // Bonus looks at registered scores, so it lands one cycle after the crossing.
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        grant = !bonus_q[p] && (score_q[p] >= BONUS_SCORE);
        dec   = declives && (cur_q == PW'(p));
        if (grant) bonus_d[p] = 1'b1;
        if (grant && dec) begin
          lives_d[p] = lives_q[p];
        end else if (grant) begin
          lives_d[p] = (lives_q[p] >= 4'(MAX_LIVES)) ? lives_q[p] : lives_q[p] + 4'd1;
        end else if (dec) begin
          lives_d[p] = (lives_q[p] == 4'd0) ? 4'd0 : lives_q[p] - 4'd1;
        end
      end

      if (declives) begin
        for (int k = 1; k <= NUM_PLAYERS; k++) begin
          if (!found && lives_d[(int'(cur_q) + k) % NUM_PLAYERS] != 4'd0) begin
            cur_d = PW'((int'(cur_q) + k) % NUM_PLAYERS);
            found = 1'b1;
          end
        end
        if (!found) begin
          state_d = S_OVER;
          cur_d   = cur_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (reset) begin
      state_q <= S_IDLE;
      // NOTE: the per-player arrays are small register banks that must read zero after reset, so they are reset explicitly.
      score_q <= '{default: '0};
      lives_q <= '{default: '0};
      bonus_q <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      lives_q <= lives_d;
      bonus_q <= bonus_d;
      cur_q   <= cur_d;
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
    assign scores[g*SW +: SW] = score_q[g];
    assign lives[g*4 +: 4]    = lives_q[g];
  end

  assign cur_player = cur_q;
  assign playing    = (state_q == S_PLAY);
  assign game_over  = (state_q == S_OVER);

`ifdef MULTI_PLAYER_STATS_HISCORE_EN
  logic [SW-1:0] hiscore_q, hiscore_d, final_max;
  logic          new_hi_q, new_hi_d;

  always_comb begin
    final_max = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (score_d[p] > final_max) final_max = score_d[p];
    end
    hiscore_d = hiscore_q;
    new_hi_d  = new_hi_q;
    if (start) begin
      new_hi_d = 1'b0;
    end else if (state_q == S_PLAY && state_d == S_OVER) begin
      // Final scores include points credited on the same edge as the last life lost.
      if (final_max > hiscore_q) begin
        hiscore_d = final_max;
        new_hi_d  = 1'b1;
      end else begin
        new_hi_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hiscore_q <= '0;
      new_hi_q  <= 1'b0;
    end else begin
      hiscore_q <= hiscore_d;
      new_hi_q  <= new_hi_d;
    end
  end

  assign hiscore     = hiscore_q;
  assign new_hiscore = new_hi_q;
`else
  assign hiscore     = '0;
  assign new_hiscore = 1'b0;
`endif

endmodule

// File: tb/tb_multi_player_stats.sv
// Scoreboard bench for multi_player_stats: a decimal-integer game model predicts every cycle,
// a monitor compares the DUT after each rising edge. Honours MULTI_PLAYER_STATS_HISCORE_EN.
module tb_multi_player_stats;

  localparam int NP        = 2;
  localparam int D         = 4;
  localparam int SW        = D * 4;
  localparam int PW        = 1;
  localparam int START     = 3;
  localparam int MAXL      = 9;
  localparam int BONUS_DEC = 1000;
  localparam int MAXS      = 10**D - 1;
`ifdef MULTI_PLAYER_STATS_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  localparam int ST_IDLE = 0;
  localparam int ST_PLAY = 1;
  localparam int ST_OVER = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic                add_pts = 1'b0;
  logic [3:0]          add_val = '0;
  logic [2:0]          add_pos = '0;
  logic                declives = 1'b0;
  logic [NP*SW-1:0]    scores;
  logic [NP*4-1:0]     lives;
  logic [PW-1:0]       cur_player;
  logic                playing;
  logic                game_over;
  logic [SW-1:0]       hiscore;
  logic                new_hiscore;

  multi_player_stats #(
    .NUM_PLAYERS (NP),
    .SCORE_DIGITS(D),
    .START_LIVES (START),
    .MAX_LIVES   (MAXL),
    .BONUS_SCORE (16'h1000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .add_pts    (add_pts),
    .add_val    (add_val),
    .add_pos    (add_pos),
    .declives   (declives),
    .scores     (scores),
    .lives      (lives),
    .cur_player (cur_player),
    .playing    (playing),
    .game_over  (game_over),
    .hiscore    (hiscore),
    .new_hiscore(new_hiscore)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP*SW-1:0] scores;
    logic [NP*4-1:0]  lives;
    logic [PW-1:0]    cur;
    logic             playing;
    logic             over;
    logic [SW-1:0]    hi;
    logic             nh;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state, kept as plain decimal integers
  int m_state;
  int m_score [NP];
  int m_lives [NP];
  bit m_bonus [NP];
  int m_cur;
  int m_hi;
  bit m_nh;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] to_bcd(input int v);
    logic [SW-1:0] r;
    int            x;
    r = '0;
    x = v;
    for (int d = 0; d < D; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic void model_reset();
    m_state = ST_IDLE;
    for (int i = 0; i < NP; i++) begin
      m_score[i] = 0;
      m_lives[i] = 0;
      m_bonus[i] = 1'b0;
    end
    m_cur = 0;
    m_hi  = 0;
    m_nh  = 1'b0;
  endfunction

  function automatic void model_step(input bit s, input bit a, input int v, input int p, input bit d);
    int old [NP];
    int add;
    int idx;
    int mx;
    bit g;
    bit mine;
    bit any;
    if (s) begin
      for (int i = 0; i < NP; i++) begin
        m_score[i] = 0;
        m_lives[i] = START;
        m_bonus[i] = 1'b0;
      end
      m_cur   = 0;
      m_state = ST_PLAY;
      m_nh    = 1'b0;
    end else if (m_state == ST_PLAY) begin
      old = m_score;
      if (a) begin
        add = (v <= 9 && p < D) ? v * pow10(p) : 0;
        m_score[m_cur] = (m_score[m_cur] + add > MAXS) ? MAXS : m_score[m_cur] + add;
      end
      for (int i = 0; i < NP; i++) begin
        g    = !m_bonus[i] && old[i] >= BONUS_DEC;
        mine = d && (i == m_cur);
        if (g) m_bonus[i] = 1'b1;
        if (g && !mine) m_lives[i] = (m_lives[i] + 1 > MAXL) ? MAXL : m_lives[i] + 1;
        if (mine && !g) m_lives[i] = (m_lives[i] > 0) ? m_lives[i] - 1 : 0;
      end
      if (d) begin
        any = 1'b0;
        for (int k = 1; k <= NP; k++) begin
          idx = (m_cur + k) % NP;
          if (!any && m_lives[idx] > 0) begin
            m_cur = idx;
            any   = 1'b1;
          end
        end
        if (!any) begin
          m_state = ST_OVER;
          if (HI_EN) begin
            mx = 0;
            for (int i = 0; i < NP; i++) if (m_score[i] > mx) mx = m_score[i];
            if (mx > m_hi) begin
              m_hi = mx;
              m_nh = 1'b1;
            end else begin
              m_nh = 1'b0;
            end
          end
        end
      end
    end
  endfunction

  function automatic exp_t snap();
    exp_t e;
    for (int i = 0; i < NP; i++) begin
      e.scores[i*SW +: SW] = to_bcd(m_score[i]);
      e.lives[i*4 +: 4]    = 4'(m_lives[i]);
    end
    e.cur     = PW'(m_cur);
    e.playing = (m_state == ST_PLAY);
    e.over    = (m_state == ST_OVER);
    e.hi      = to_bcd(m_hi);
    e.nh      = m_nh;
    return e;
  endfunction

  task automatic cmp(input exp_t e, input string tag);
    check({tag, ".scores"},      64'(scores),      64'(e.scores));
    check({tag, ".lives"},       64'(lives),       64'(e.lives));
    check({tag, ".cur_player"},  64'(cur_player),  64'(e.cur));
    check({tag, ".playing"},     64'(playing),     64'(e.playing));
    check({tag, ".game_over"},   64'(game_over),   64'(e.over));
    check({tag, ".hiscore"},     64'(hiscore),     64'(e.hi));
    check({tag, ".new_hiscore"}, 64'(new_hiscore), 64'(e.nh));
  endtask

  // Monitor: pops one expected snapshot per rising edge once stimulus has queued one
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp(e, "mon");
      end
    end
  end

  task automatic drive(input bit s, input bit a, input int v, input int p, input bit d);
    @(negedge clk);
    reset    = 1'b0;
    start    = s;
    add_pts  = a;
    add_val  = 4'(v);
    add_pos  = 3'(p);
    declives = d;
    model_step(s, a, v, p, d);
    q.push_back(snap());
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Reset asserted mid-cycle with events active: outputs must clear before any edge
  task automatic drive_reset();
    @(negedge clk);
    reset    = 1'b1;
    start    = 1'b0;
    add_pts  = 1'b1;
    add_val  = 4'd5;
    add_pos  = 3'd0;
    declives = 1'b1;
    model_reset();
    #1;
    cmp(snap(), "async_reset");
    q.push_back(snap());
    @(negedge clk);
    reset    = 1'b0;
    model_step(0, 1, 5, 0, 1);
    q.push_back(snap());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    cmp(snap(), "por");

    // Events in IDLE are ignored
    drive(0, 1, 7, 0, 1);
    idle();

    // Two additions of 7
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 7, 0, 0);
    drive(0, 1, 7, 0, 0);
    settle();
    check("add7x2.score", 64'(scores[15:0]), 64'h0014);
    check("add7x2.lives", 64'(lives), 64'h33);
    check("add7x2.cur", 64'(cur_player), 64'd0);

    // Carry into the bonus threshold, bonus granted once
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 9, 2, 0);
    drive(0, 1, 9, 1, 0);
    drive(0, 1, 9, 0, 0);
    drive(0, 1, 1, 0, 0);
    settle();
    check("carry.score", 64'(scores[15:0]), 64'h1000);
    idle();
    settle();
    check("bonus.lives", 64'(lives[3:0]), 64'd4);
    drive(0, 1, 9, 3, 0);
    idle();
    idle();
    settle();
    check("bonus_once.lives", 64'(lives[3:0]), 64'd4);
    check("sat_via_thousands", 64'(scores[15:0]), 64'h9999);

    // Saturation from 9995 plus 90; out-of-range value and position are no-ops
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 9, 3, 0);
    drive(0, 1, 9, 2, 0);
    drive(0, 1, 9, 1, 0);
    drive(0, 1, 5, 0, 0);
    drive(0, 1, 12, 0, 0);
    drive(0, 1, 3, 5, 0);
    drive(0, 1, 9, 1, 0);
    settle();
    check("saturate.score", 64'(scores[15:0]), 64'h9999);

    // Bonus and life loss on the same player in one cycle cancel out
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 1, 3, 0);
    drive(0, 0, 0, 0, 1);
    settle();
    check("bonus_dec.lives", 64'(lives), 64'h33);
    check("bonus_dec.cur", 64'(cur_player), 64'd1);

    // Alternating turns, elimination, game over
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    settle();
    check("alt.lives22", 64'(lives), 64'h22);
    drive(0, 0, 0, 0, 1);
    settle();
    check("alt.lives12", 64'(lives), 64'h21);
    check("alt.cur", 64'(cur_player), 64'd1);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 1, 3, 0);
    idle();
    repeat (6) drive(0, 0, 0, 0, 1);
    settle();
    check("elim1.lives", 64'(lives), 64'h01);
    check("elim1.cur", 64'(cur_player), 64'd0);
    drive(0, 0, 0, 0, 1);
    settle();
    check("over.flag", 64'(game_over), 64'd1);
    drive(0, 1, 5, 0, 1);
    settle();
    check("over.hold_score", 64'(scores[15:0]), 64'h1000);

    // Start coinciding with other events wins
    drive(1, 1, 9, 0, 1);

    // Reset mid-game with points pending; events ignored until start
    drive(0, 1, 2, 1, 0);
    drive_reset();
    drive(0, 1, 5, 0, 0);
    settle();
    check("post_reset.scores", 64'(scores), 64'd0);
    check("post_reset.playing", 64'(playing), 64'd0);

    // High-score games
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 1, 2, 0);
    drive(0, 1, 2, 1, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 1, 4, 2, 0);
    drive(0, 1, 5, 1, 0);
    repeat (5) drive(0, 0, 0, 0, 1);
    settle();
    check("hi1.scores", 64'(scores), 64'h0450_0120);
    check("hi1.hiscore", 64'(hiscore), HI_EN ? 64'h0450 : 64'h0);
    check("hi1.new", 64'(new_hiscore), HI_EN ? 64'd1 : 64'd0);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 3, 2, 0);
    repeat (6) drive(0, 0, 0, 0, 1);
    settle();
    check("hi2.over", 64'(game_over), 64'd1);
    check("hi2.hiscore", 64'(hiscore), HI_EN ? 64'h0450 : 64'h0);
    check("hi2.new", 64'(new_hiscore), 64'd0);

    // Randomized play
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        drive_reset();
      end else begin
        drive($urandom_range(0, 49) == 0,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 15),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 2),
              $urandom_range(0, 7) == 0);
      end
    end

    @(posedge clk);
    #3;
    check("sb_drain", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
